// File: rtl/feistel_pkg.sv
// ============================================================================
// Module : feistel_pkg
// Brief  : Shared constants for the iterative Feistel encrypt engine.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package feistel_pkg;

  localparam int DATA_WIDTH_DEF = 256;
  localparam int HALF           = DATA_WIDTH_DEF / 2;
  localparam int RND_W          = 3;
  localparam int F_LAT_DEF      = 6;
  localparam int TIMEOUT_MULT   = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

endpackage

`default_nettype wire

// File: rtl/feistel_encrypt_iter_if.sv
// ============================================================================
// Module : feistel_encrypt_iter_if
// Brief  : Key-load, S-box load and plaintext/ciphertext handshake bundle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface feistel_encrypt_iter_if #(
  parameter int DATA_WIDTH = 256,
  parameter int KEY_SIZE   = 128,
  parameter int SBOX_WIDTH = 8
);

  logic [SBOX_WIDTH-1:0] sbox_out;
  logic                  sbox_valid;
  logic                  key_valid;
  logic [KEY_SIZE-1:0]   K0;
  logic [KEY_SIZE-1:0]   K1;
  logic [KEY_SIZE-1:0]   K2;
  logic [KEY_SIZE-1:0]   K3;
  logic [KEY_SIZE-1:0]   K4;
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] plaintext;
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] ciphertext;
  logic                  err;

  modport master (
    output sbox_out, sbox_valid, key_valid, K0, K1, K2, K3, K4,
    output tvalid, plaintext, ready,
    input  tready, valid, ciphertext, err
  );

  modport slave (
    input  sbox_out, sbox_valid, key_valid, K0, K1, K2, K3, K4,
    input  tvalid, plaintext, ready,
    output tready, valid, ciphertext, err
  );

endinterface

`default_nettype wire

// File: rtl/feistel_encrypt_iter_f.sv
// ============================================================================
// Module : feistel_encrypt_iter_f
// Brief  : Programmable-S-box round function, fixed latency F_LAT.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module feistel_encrypt_iter_f #(
  parameter int F_LAT      = 6,
  parameter int SBOX_WIDTH = 8,
  parameter int WIDTH      = 128
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [SBOX_WIDTH-1:0] sbox_out,
  input  logic                  sbox_valid,
  input  logic                  tvalid,
  input  logic [WIDTH-1:0]      state_in,
  input  logic [WIDTH-1:0]      round_key,
  output logic                  valid,
  output logic [WIDTH-1:0]      state_out
);

  localparam int DEPTH = 1 << SBOX_WIDTH;
  localparam int LANES = WIDTH / SBOX_WIDTH;

  logic [SBOX_WIDTH-1:0] sbox_mem [DEPTH];
  logic [SBOX_WIDTH-1:0] wr_ptr;
  logic [WIDTH-1:0]      mixed;
  logic [WIDTH-1:0]      subst;
  logic [WIDTH-1:0]      result;
  logic [F_LAT-1:0]      vpipe;

  // S-box contents survive reset; only the load pointer restarts.
  always_ff @(posedge clk) begin
    if (sbox_valid) sbox_mem[wr_ptr] <= sbox_out;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        wr_ptr <= '0;
    else if (sbox_valid) wr_ptr <= wr_ptr + 1'b1;
  end

  assign mixed = state_in ^ round_key;

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign subst[i*SBOX_WIDTH +: SBOX_WIDTH] = sbox_mem[mixed[i*SBOX_WIDTH +: SBOX_WIDTH]];
    end
  endgenerate

  // One block in flight, so a single result register plus a valid delay line suffices.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vpipe  <= '0;
      result <= '0;
    end else begin
      vpipe <= {vpipe[F_LAT-2:0], tvalid};
      if (tvalid) result <= subst ^ {subst[WIDTH-SBOX_WIDTH-1:0], subst[WIDTH-1 -: SBOX_WIDTH]};
    end
  end

  assign valid     = vpipe[F_LAT-1];
  assign state_out = result;

endmodule

`default_nettype wire

// File: rtl/feistel_encrypt_iter.sv
// ============================================================================
// Module : feistel_encrypt_iter
// Brief  : Iterative 5-round Feistel encryptor sharing one F instance.
//          Optional macro FEISTEL_ENC_TIMEOUT_EN adds a WAIT timeout on err.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module feistel_encrypt_iter
  import feistel_pkg::*;
#(
  parameter int ROUND      = 5,
  parameter int F_LAT      = F_LAT_DEF,
  parameter int SBOX_WIDTH = 8,
  parameter int KEY_SIZE   = 128,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  feistel_encrypt_iter_if.slave  bus
);

  localparam int              HW       = DATA_WIDTH / 2;
  localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUND - 1);

  logic [1:0]          state;
  logic [RND_W-1:0]    rnd;
  logic                key_loaded;
  logic [KEY_SIZE-1:0] key_reg [ROUND];
  logic [HW-1:0]       l_half;
  logic [HW-1:0]       r_half;
  logic [HW-1:0]       r_next;
  logic                tready_w;
  logic                f_tvalid;
  logic                f_valid;
  logic [HW-1:0]       f_out;
  logic                valid_q;
  logic [DATA_WIDTH-1:0] ct_q;

  assign tready_w = (state == S_IDLE) && key_loaded && !bus.key_valid;
  assign f_tvalid = (state == S_ISSUE);
  assign r_next   = l_half ^ f_out;

  // Keys are only taken in IDLE so the block in flight always sees a frozen set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_loaded <= 1'b0;
      for (int i = 0; i < ROUND; i++) key_reg[i] <= '0;
    end else if (state == S_IDLE && bus.key_valid) begin
      key_loaded <= 1'b1;
      key_reg[0] <= bus.K0;
      key_reg[1] <= bus.K1;
      key_reg[2] <= bus.K2;
      key_reg[3] <= bus.K3;
      key_reg[4] <= bus.K4;
    end
  end

`ifdef FEISTEL_ENC_TIMEOUT_EN
  localparam int TIMEOUT = TIMEOUT_MULT * F_LAT;
  localparam int WC_W    = $clog2(TIMEOUT + 1);

  logic [WC_W-1:0] wait_cnt;
  logic            err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              wait_cnt <= '0;
    else if (state != S_WAIT)  wait_cnt <= '0;
    else                       wait_cnt <= wait_cnt + 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      rnd     <= '0;
      l_half  <= '0;
      r_half  <= '0;
      valid_q <= 1'b0;
      ct_q    <= '0;
`ifdef FEISTEL_ENC_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
`ifdef FEISTEL_ENC_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (bus.tvalid && tready_w) begin
            l_half <= bus.plaintext[DATA_WIDTH-1:HW];
            r_half <= bus.plaintext[HW-1:0];
            rnd    <= '0;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (f_valid) begin
            l_half <= r_half;
            r_half <= r_next;
            if (rnd == LAST_RND) begin
              // Final halves are emitted swapped so decrypt can reuse the same structure.
              valid_q <= 1'b1;
              ct_q    <= {r_next, r_half};
              state   <= S_OUT;
            end else begin
              rnd   <= rnd + 1'b1;
              state <= S_ISSUE;
            end
          end
`ifdef FEISTEL_ENC_TIMEOUT_EN
          else if (wait_cnt == WC_W'(TIMEOUT - 1)) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end
`endif
        end
        S_OUT: begin
          if (bus.ready) begin
            valid_q <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  feistel_encrypt_iter_f #(
    .F_LAT      (F_LAT),
    .SBOX_WIDTH (SBOX_WIDTH),
    .WIDTH      (HW)
  ) u_f (
    .clk        (clk),
    .reset_n    (reset_n),
    .sbox_out   (bus.sbox_out),
    .sbox_valid (bus.sbox_valid),
    .tvalid     (f_tvalid),
    .state_in   (r_half),
    .round_key  (key_reg[rnd]),
    .valid      (f_valid),
    .state_out  (f_out)
  );

  assign bus.tready     = tready_w;
  assign bus.valid      = valid_q;
  assign bus.ciphertext = ct_q;
`ifdef FEISTEL_ENC_TIMEOUT_EN
  assign bus.err        = err_q;
`else
  assign bus.err        = 1'b0;
`endif

endmodule

`default_nettype wire
